// File: rtl/i2s_tx_if.sv
//------------------------------------------------------------------------------
// Module      : i2s_tx_if
// Description : Sample stream from the synthesizer into the I2S transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface i2s_tx_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

`default_nettype wire

// File: rtl/i2s_tx.sv
//------------------------------------------------------------------------------
// Module      : i2s_tx
// Description : FIFO-buffered I2S transmitter; mono sample sent on both slots.
//               Define I2S_TX_HOLD_LAST_EN to repeat the last word on underrun.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          enable,
    input  wire logic                          clear_flags,
    i2s_tx_if.slave                            smp,
    output      logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output      logic                          overflow,
    output      logic                          underrun,
    output      logic                          i2s_bclk,
    output      logic                          i2s_lrclk,
    output      logic                          i2s_sdata
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W  = $clog2(2 * DATA_WIDTH);
    localparam int c_IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(2 * DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(DATA_WIDTH);
    localparam logic [c_DIV_W-1:0] c_DIV_TOP  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;

    logic                  r_run;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_overflow;
    logic                  r_underrun;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_active;
    logic                  w_wrap;
    logic                  w_fall;
    logic                  w_frame_end;
    logic                  w_pop_req;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_starve;
    logic [c_BIT_W-1:0]    w_next_bit;
    logic [c_BIT_W-1:0]    w_off;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_bit;
    logic [DATA_WIDTH-1:0] w_pop_word;

    assign w_full      = (r_level == c_FULL_LVL);
    assign w_empty     = (r_level == '0);
    // r_run delays the start by one cycle so BCLK first rises CLK_DIV edges
    // after enable is sampled; dropping enable still acts on the next edge.
    assign w_active    = enable && r_run;
    assign w_wrap      = w_active && (r_div_cnt == c_DIV_TOP);
    assign w_fall      = w_wrap && r_bclk;
    assign w_frame_end = (r_bit_cnt == c_LAST_BIT);
    assign w_pop_req   = w_fall && w_frame_end;
    assign w_pop       = w_pop_req && !w_empty;
    assign w_starve    = w_pop_req && w_empty;
    assign w_push      = smp.sample_valid && (!w_full || w_pop);
    assign w_drop      = smp.sample_valid && w_full && !w_pop;
    assign w_next_bit  = r_bit_cnt + c_BIT_W'(1);

    // The bit shown after a fall is selected by the pre-increment count,
    // folded onto a single slot since both slots carry the same word.
    always_comb begin
        w_off = (r_bit_cnt >= c_SLOT) ? (r_bit_cnt - c_SLOT) : r_bit_cnt;
        w_idx = c_IDX_W'(c_SLOT - c_BIT_W'(1) - w_off);
        w_bit = r_word[w_idx];
    end

    always_comb begin
        if (!w_empty) begin
            w_pop_word = r_mem[r_rd_ptr];
        end else begin
`ifdef I2S_TX_HOLD_LAST_EN
            w_pop_word = r_word;
`else
            w_pop_word = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= smp.sample_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= c_LAST_BIT;
            r_word    <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            r_run <= enable;
            if (!enable) begin
                r_div_cnt <= '0;
                r_bit_cnt <= c_LAST_BIT;
                r_word    <= '0;
                r_bclk    <= 1'b0;
                r_lrclk   <= 1'b0;
                r_sdata   <= 1'b0;
            end else if (r_run) begin
                if (w_wrap) begin
                    r_div_cnt <= '0;
                    r_bclk    <= ~r_bclk;
                end else begin
                    r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                end
                if (w_fall) begin
                    if (w_frame_end) begin
                        // Right-slot LSB of the outgoing word lands in slot 0.
                        r_bit_cnt <= '0;
                        r_word    <= w_pop_word;
                        r_sdata   <= r_word[0];
                        r_lrclk   <= 1'b0;
                    end else begin
                        r_bit_cnt <= w_next_bit;
                        r_sdata   <= w_bit;
                        r_lrclk   <= (w_next_bit >= c_SLOT);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_starve) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign smp.sample_ready = !w_full;
    assign fifo_level       = r_level;
    assign overflow         = r_overflow;
    assign underrun         = r_underrun;
    assign i2s_bclk         = r_bclk;
    assign i2s_lrclk        = r_lrclk;
    assign i2s_sdata        = r_sdata;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_i2s_tx
// Description : Scoreboard bench for i2s_tx (DATA_WIDTH=16, FIFO_DEPTH=8, CLK_DIV=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2s_tx;

    localparam int DW  = 16;
    localparam int FD  = 8;
    localparam int DIV = 2;

    typedef struct packed {
        logic sd;
        logic lr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear_flags = 1'b0;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       underrun;
    logic       i2s_bclk;
    logic       i2s_lrclk;
    logic       i2s_sdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_fall = 0;
    bit   mon_on = 1'b0;
    logic prev_bclk = 1'b0;
    exp_t q[$];

    i2s_tx_if #(.DATA_WIDTH(DW)) smp ();

    i2s_tx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .CLK_DIV    (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_flags (clear_flags),
        .smp         (smp.slave),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underrun    (underrun),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fall0(input logic [DW-1:0] prev);
        q.push_back('{sd: prev[0], lr: 1'b0});
    endtask

    // Falls 1..n of a frame carrying word w (n = 2*DW-1 for a full frame).
    task automatic push_body(input logic [DW-1:0] w, input int n);
        for (int b = 1; b <= n; b++) begin
            q.push_back('{sd: w[DW-1-((b-1)%DW)], lr: (b >= DW)});
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int k = 0;
        while (q.size() != 0 && k < max_cyc) begin
            step();
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic write_burst(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            smp.sample_in    = first + DW'(i);
            smp.sample_valid = 1'b1;
            step();
        end
        smp.sample_valid = 1'b0;
    endtask

    task automatic stop_and_clear();
        enable = 1'b0;
        step();
        q.delete();
        mon_on = 1'b0;
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    // Monitor: every BCLK fall while running is checked against the queue head.
    always @(negedge clk) begin
        if (mon_on && enable && !rst && prev_bclk && !i2s_bclk) begin
            if (q.size() == 0) begin
                chk("unexpected_fall", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("sdata_fall%0d", n_fall), i2s_sdata, e.sd);
                chk($sformatf("lrclk_fall%0d", n_fall), i2s_lrclk, e.lr);
            end
            n_fall++;
        end
        prev_bclk = i2s_bclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w_u;
        int            k;
        smp.sample_in    = '0;
        smp.sample_valid = 1'b0;

        // Reset state
        #3;
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_lrclk", i2s_lrclk, 0);
        chk("rst_sdata", i2s_sdata, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", smp.sample_ready, 1);
        chk("rst_flags", {overflow, underrun}, 0);
        step();
        step();
        rst = 1'b0;

        // Single frame of A5F0 then an underrunning pop
        write_burst(16'hA5F0, 1);
        chk("level_after_write", fifo_level, 1);
        push_fall0('0);
        push_body(16'hA5F0, 2*DW-1);
        push_fall0(16'hA5F0);
        mon_on = 1'b1;
        enable = 1'b1;
        for (int e = 0; e <= 2*DIV; e++) begin
            step();
            if (e == DIV) chk("start_bclk_rise", i2s_bclk, 1);
            if (e == 2*DIV) begin
                chk("first_fall_bclk", i2s_bclk, 0);
                chk("first_fall_lrclk", i2s_lrclk, 0);
                chk("first_pop_level", fifo_level, 0);
            end
        end
        wait_drain(1000, "frame1_drain");
        chk("frame1_underrun", underrun, 1);
        stop_and_clear();
        chk("frame1_clear", underrun, 0);

        // Underrun frame after 1234
`ifdef I2S_TX_HOLD_LAST_EN
        w_u = 16'h1234;
`else
        w_u = 16'h0000;
`endif
        write_burst(16'h1234, 1);
        push_fall0('0);
        push_body(16'h1234, 2*DW-1);
        push_fall0(16'h1234);
        push_body(w_u, 2*DW-1);
        push_fall0(w_u);
        mon_on = 1'b1;
        enable = 1'b1;
        wait_drain(1000, "underrun_drain");
        chk("underrun_flag", underrun, 1);
        chk("underrun_no_ovf", overflow, 0);
        stop_and_clear();
        chk("underrun_clear", underrun, 0);

        // Overflow: nine writes into eight entries
        write_burst(16'h1001, 9);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_ready", smp.sample_ready, 0);
        chk("ovf_flag", overflow, 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Full FIFO: write coincides with the first pop
        push_fall0('0);
        for (int i = 0; i < 8; i++) begin
            push_body(16'h1001 + DW'(i), 2*DW-1);
            push_fall0(16'h1001 + DW'(i));
        end
        push_body(16'hBEEF, 2*DW-1);
        push_fall0(16'hBEEF);
        mon_on = 1'b1;
        enable = 1'b1;
        for (int e = 0; e <= 2*DIV; e++) begin
            step();
            if (e == 2*DIV-1) begin
                smp.sample_in    = 16'hBEEF;
                smp.sample_valid = 1'b1;
            end
            if (e == 2*DIV) begin
                smp.sample_valid = 1'b0;
                chk("fullpop_level", fifo_level, 8);
                chk("fullpop_no_ovf", overflow, 0);
            end
        end
        wait_drain(4000, "fullpop_drain");
        chk("fullpop_underrun", underrun, 1);
        stop_and_clear();

        // Enable dropped at bit_cnt = 7
        write_burst(16'hC3A5, 2);
        chk("drop_level_pre", fifo_level, 2);
        push_fall0('0);
        push_body(16'hC3A5, 7);
        mon_on = 1'b1;
        enable = 1'b1;
        wait_drain(200, "drop_drain");
        chk("drop_sdata_pre", i2s_sdata, 1);
        enable = 1'b0;
        step();
        chk("drop_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata}, 0);
        chk("drop_level", fifo_level, 1);
        q.delete();
        mon_on = 1'b0;

        // Asynchronous reset mid-frame
        enable = 1'b1;
        write_burst(16'h7777, 1);
        k = 0;
        while (i2s_sdata !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("arst_reach_sdata", i2s_sdata, 1);
        chk("arst_level_pre", fifo_level, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata}, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ready", smp.sample_ready, 1);
        step();
        rst = 1'b0;
        for (int e = 0; e <= 2*DIV; e++) begin
            step();
            if (e == DIV) chk("restart_bclk", i2s_bclk, 1);
            if (e == 2*DIV) chk("restart_underrun", underrun, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

I2S audio transmitter that consumes the synthesizer's `sample`/`sample_valid` stream and serializes it to an external audio DAC. It buffers incoming samples in a small FIFO and generates BCLK/LRCLK from the system clock. It emits each mono sample on both the left and right slots in standard I2S framing, with a one-BCLK data delay after each LRCLK edge. It sits between `fm_synth` and the board pins.

## Interface
- `DATA_WIDTH`, 16, sample width and I2S slot width in bits.
- `FIFO_DEPTH`, 8, FIFO entries; must be a power of 2 and at least 2.
- `CLK_DIV`, 4, `clk` cycles per BCLK half-period; must be at least 1.

Ports:
- `clk` input 1 system clock; all logic is on the rising edge.
- `rst` input 1 asynchronous, active-high reset.
- `enable` input 1 serializer run; the FIFO accepts writes regardless of this input.
- `clear_flags` input 1 single-cycle pulse that clears `overflow` and `underrun`.
- `sample_in` input DATA_WIDTH signed sample, connected to `fm_synth.sample`.
- `sample_valid` input 1 write strobe.
- `sample_ready` output 1 high when the FIFO is not full; `fm_synth` ignores it.
- `fifo_level` output $clog2(FIFO_DEPTH)+1 current FIFO occupancy.
- `overflow` output 1 sticky flag: a write was dropped.
- `underrun` output 1 sticky flag: a pop found the FIFO empty.
- `i2s_bclk` output 1 bit clock, registered.
- `i2s_lrclk` output 1 word select: 0 = left, 1 = right. Registered.
- `i2s_sdata` output 1 serial data, MSB first, registered.

## Operation
- Reset:
  - all outputs are 0 and the FIFO is empty.
  - `div_cnt` = 0, `bit_cnt` = 2*DATA_WIDTH-1, shift word = 0.
- FIFO write: when `sample_valid` is high and the FIFO is not full, `sample_in` is pushed.
- Full FIFO: a write is dropped and `overflow` is set, unless a pop occurs in the same cycle. Pop plus write when full accepts the write and leaves the level unchanged.
- Divider:
  - while `enable` is high, `div_cnt` counts 0..CLK_DIV-1.
  - at CLK_DIV-1 it wraps and `i2s_bclk` toggles.
  - a 1→0 toggle is a "fall event".
- Fall event, when `bit_cnt` = 2*DATA_WIDTH-1:
  - `bit_cnt` becomes 0 and one word W is popped.
  - `i2s_sdata` = bit 0 of the previous word (right-slot LSB).
  - `i2s_lrclk` = 0.
- Fall event otherwise:
  - `bit_cnt` increments.
  - `i2s_lrclk` = (new `bit_cnt` >= DATA_WIDTH).
  - `i2s_sdata` = W[DATA_WIDTH-1-((new `bit_cnt`-1) mod DATA_WIDTH)].
  - Result: left bits on `bit_cnt` 1..DATA_WIDTH, right MSB..bit1 on DATA_WIDTH+1..2*DATA_WIDTH-1, right LSB on the next 0.
- Pop on an empty FIFO: W = 0 and `underrun` is set.
- `enable` low:
  - takes effect synchronously at the next `clk` edge.
  - `div_cnt`, `bit_cnt` and the shift word return to their reset values.
  - `i2s_bclk`, `i2s_lrclk` and `i2s_sdata` are driven to 0.
  - FIFO contents are retained.
- `clear_flags`: clears both sticky flags. A set event in the same cycle wins.

## Timing
- Write-to-level latency: `fifo_level` updates 1 cycle after the write.
- BCLK period: 2*CLK_DIV `clk` cycles.
- Frame length: 2*DATA_WIDTH BCLKs.
- Start-up: with `enable` sampled high at edge 0, BCLK rises at edge CLK_DIV. The first fall event and first pop happen at edge 2*CLK_DIV.
- `i2s_sdata` and `i2s_lrclk` change only on fall events, so the DAC samples them on the BCLK rising edge.
- Asynchronous reset mid-frame: outputs clear immediately. After `rst` is released, the frame restarts from the reset state.

## Configuration
- `I2S_TX_HOLD_LAST_EN` defined: a pop on an empty FIFO reloads the previous word instead of 0. `underrun` is still set.
- Macro undefined: a pop on an empty FIFO outputs zeros, as described in Operation.

## Test plan
- Reset: assert `rst` asynchronously mid-frame. Required: all outputs 0 immediately, `fifo_level` = 0, `sample_ready` = 1.
- Single frame (DATA_WIDTH=16, CLK_DIV=2):
  - stimulus: write 16'hA5F0 with `enable` low, then raise `enable`.
  - required: first fall at cycle 4, `i2s_lrclk` = 0.
  - required: fall events 1..16 show A5F0 MSB first; `i2s_lrclk` = 1 from fall 16.
  - required: falls 17..31 and the following fall 0 show A5F0 again; `underrun` = 1 at that next pop.
- Overflow: with `enable` low, write 9 samples back-to-back. Required: `fifo_level` = 8, `sample_ready` = 0, `overflow` = 1, the 9th sample is absent from the output.
- Full plus pop: FIFO full, a write coincides with a pop. Required: level stays 8, `overflow` stays 0, the written word appears last.
- Underrun:
  - stimulus: enable with an empty FIFO after one word 16'h1234 has been sent.
  - macro off: `i2s_sdata` = 0 for the whole frame.
  - macro on: the frame repeats 16'h1234.
  - required in both builds: `underrun` = 1, and `clear_flags` clears it.
- Enable drop mid-frame: deassert `enable` at `bit_cnt` = 7. Required: BCLK/LRCLK/SDATA = 0 on the next cycle, and the FIFO level is unchanged.
